// File: rtl/mips_core_pkg.sv
// Shared core types and sizing constants for the MIPS front end.
package mips_core_pkg;

    localparam int unsigned INSTRUCTION_QUEUE_DEPTH      = 2;
    localparam int unsigned INSTRUCTION_QUEUE_DEPTH_BITS = 1;

    // Fetched instruction: program counter (upper bits) and instruction word.
    typedef struct packed {
        logic [25:0] pc;
        logic [31:0] data;
    } inst;

endpackage

// File: rtl/instruction_queue.sv
// Fetch-to-decode instruction queue: power-of-two circular buffer with flush.
// Optional empty-queue fall-through path enabled by INSTRUCTION_QUEUE_BYPASS_EN.
module instruction_queue
    import mips_core_pkg::*;
#(
    parameter int unsigned DEPTH      = INSTRUCTION_QUEUE_DEPTH,
    parameter int unsigned DEPTH_BITS = INSTRUCTION_QUEUE_DEPTH_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  inst                 in_inst,
    output logic                in_ready,
    output logic                out_valid,
    output inst                 out_inst,
    input  logic                out_ready,
    input  logic                flush,
    output logic [DEPTH_BITS:0] count
);

    localparam int unsigned CW = DEPTH_BITS + 1;
    localparam int unsigned PW = DEPTH_BITS;

    inst             mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_n;
    logic            in_ready_q;
    logic            valid_q;
    logic            thru_c;
    logic            push_c;
    logic            pop_c;
    logic            store_c;
    logic            take_c;

`ifdef INSTRUCTION_QUEUE_BYPASS_EN
    // An empty queue presents the incoming instruction directly.
    assign out_valid = valid_q | in_valid;
    assign out_inst  = valid_q ? mem[rd_ptr] : in_inst;
    assign thru_c    = !valid_q && in_valid && out_ready && !flush;
`else
    assign out_valid = valid_q;
    assign out_inst  = mem[rd_ptr];
    assign thru_c    = 1'b0;
`endif

    assign in_ready = in_ready_q;
    assign count    = count_q;

    assign push_c  = in_valid && in_ready_q && !flush;
    assign pop_c   = out_valid && out_ready && !flush;
    // A fall-through transfer touches neither storage nor occupancy.
    assign store_c = push_c && !thru_c;
    assign take_c  = pop_c && !thru_c;

    always_comb begin
        count_n = count_q;
        unique case ({store_c, take_c})
            2'b10:   count_n = count_q + CW'(1);
            2'b01:   count_n = count_q - CW'(1);
            default: count_n = count_q;
        endcase
    end

    // Pointers, occupancy and the registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            if (store_c) wr_ptr <= wr_ptr + PW'(1);
            if (take_c)  rd_ptr <= rd_ptr + PW'(1);
            count_q    <= count_n;
            in_ready_q <= (count_n != CW'(DEPTH));
            valid_q    <= (count_n != '0);
        end
    end

    // Storage is never cleared; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (!rst && store_c) mem[wr_ptr] <= in_inst;
    end

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue against a queue-based reference model.
// Expectations follow INSTRUCTION_QUEUE_BYPASS_EN when the bench is built with it.
module tb_instruction_queue;
    import mips_core_pkg::*;

    localparam int unsigned DEPTH      = INSTRUCTION_QUEUE_DEPTH;
    localparam int unsigned DEPTH_BITS = INSTRUCTION_QUEUE_DEPTH_BITS;
    localparam int unsigned CW         = DEPTH_BITS + 1;

`ifdef INSTRUCTION_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    inst           in_inst;
    logic          in_ready;
    logic          out_valid;
    inst           out_inst;
    logic          out_ready;
    logic          flush;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    inst mq[$];

    instruction_queue #(.DEPTH(DEPTH), .DEPTH_BITS(DEPTH_BITS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(in_ready), .out_valid(out_valid), .out_inst(out_inst),
        .out_ready(out_ready), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    function automatic inst mk(input logic [25:0] pc);
        inst t;
        t.pc   = pc;
        t.data = $urandom;
        return t;
    endfunction

    task automatic drive(input logic iv, input inst ii, input logic ordy,
                         input logic fl, input logic r);
        in_valid  = iv;
        in_inst   = ii;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst       = 1'b0;
    endtask

    // Advance one clock: model applies the queue rules to the pre-edge inputs.
    task automatic tick();
        int  sz;
        bit  thru;
        bit  do_pop;
        bit  do_push;
        sz = mq.size();
        if (rst || flush) begin
            mq.delete();
        end else begin
            thru    = BYP && (sz == 0) && in_valid && out_ready;
            do_pop  = (sz != 0) && out_ready;
            do_push = in_valid && (sz != DEPTH) && !thru;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(in_inst);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, mk(26'h3), 1'b1, 1'b0, 1'b1);
        tick(); tick();
        idle(); #1;
        total++;
        if (count !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset: count=%0d in_ready=%b out_valid=%b want 0/1/0", count, in_ready, out_valid);
        end
    endtask

    task automatic test_single_push();
        inst a;
        a.pc = 26'h10; a.data = 32'h2402000A;
        drive(1'b1, a, 1'b0, 1'b0, 1'b0);
        tick(); idle(); #1;
        total++;
        if (out_valid !== 1'b1 || out_inst !== a || count !== CW'(1)) begin
            bad++;
            $display("FAIL single_push: valid=%b pc=%h data=%h count=%0d want 1/10/2402000a/1",
                     out_valid, out_inst.pc, out_inst.data, count);
        end
        drive(1'b0, a, 1'b1, 1'b0, 1'b0);
        tick(); idle(); #1;
        total++;
        if (count !== '0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_pop: count=%0d valid=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_fill();
        inst a, b, c;
        a = mk(26'h10); b = mk(26'h14); c = mk(26'h18);
        drive(1'b1, a, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, b, 1'b0, 1'b0, 1'b0); tick();
        idle(); #1;
        total++;
        if (count !== CW'(2) || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill: count=%0d in_ready=%b want 2/0", count, in_ready);
        end
        drive(1'b1, c, 1'b0, 1'b0, 1'b0); tick(); idle(); #1;
        total++;
        if (count !== CW'(2) || out_inst !== a) begin
            bad++;
            $display("FAIL full_push_ignored: count=%0d head=%h want 2/10", count, out_inst.pc);
        end
        // Pop while full with a push offered: the push must not be admitted.
        drive(1'b1, c, 1'b1, 1'b0, 1'b0); tick(); idle(); #1;
        total++;
        if (count !== CW'(1) || out_inst !== b) begin
            bad++;
            $display("FAIL full_pop_push: count=%0d head=%h want 1/14", count, out_inst.pc);
        end
        drive(1'b0, c, 1'b1, 1'b0, 1'b0); tick(); idle(); #1;
        total++;
        if (count !== '0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain: count=%0d valid=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [25:0] want_pc;
        drive(1'b1, mk(26'h1C), 1'b0, 1'b0, 1'b0); tick();
        want_pc = 26'h1C;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, mk(26'h20 + 26'(4 * i)), 1'b1, 1'b0, 1'b0);
            #1;
            total++;
            if (out_valid !== 1'b1 || out_inst.pc !== want_pc || count !== CW'(1)
                || mq.size() == 0 || out_inst !== mq[0]) begin
                bad++;
                $display("FAIL back_to_back[%0d]: valid=%b pc=%h count=%0d want 1/%h/1",
                         i, out_valid, out_inst.pc, count, want_pc);
            end
            tick();
            want_pc = 26'h20 + 26'(4 * i);
        end
        drive(1'b0, in_inst, 1'b1, 1'b0, 1'b0); tick(); idle(); #1;
    endtask

    task automatic test_flush();
        drive(1'b1, mk(26'h30), 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, mk(26'h34), 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, mk(26'h40), 1'b1, 1'b1, 1'b0); tick();
        idle(); #1;
        total++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush: count=%0d valid=%b in_ready=%b want 0/0/1", count, out_valid, in_ready);
        end
        // Pointers restart at zero: next entry is the head.
        drive(1'b1, mk(26'h44), 1'b0, 1'b0, 1'b0); tick(); idle(); #1;
        total++;
        if (out_valid !== 1'b1 || out_inst.pc !== 26'h44 || count !== CW'(1)) begin
            bad++;
            $display("FAIL after_flush: valid=%b pc=%h count=%0d want 1/44/1", out_valid, out_inst.pc, count);
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b1, mk(26'h48), 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, mk(26'h4C), 1'b1, 1'b1, 1'b1); tick();
        idle(); #1;
        total++;
        if (count !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_priority: count=%0d in_ready=%b valid=%b want 0/1/0", count, in_ready, out_valid);
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, mk(26'h50), 1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if (out_valid !== BYP || (BYP && out_inst.pc !== 26'h50)) begin
            bad++;
            $display("FAIL bypass_same_cycle: valid=%b pc=%h want %b/50", out_valid, out_inst.pc, BYP);
        end
        tick(); idle(); #1;
        total++;
        if (count !== (BYP ? CW'(0) : CW'(1))) begin
            bad++;
            $display("FAIL bypass_count: count=%0d want %0d", count, BYP ? 0 : 1);
        end
        drive(1'b0, in_inst, 1'b1, 1'b0, 1'b0); tick(); idle(); #1;
    endtask

    task automatic test_random();
        bit  exp_v;
        inst exp_i;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), mk(26'($urandom)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 49) == 0));
            #1;
            exp_v = (mq.size() != 0) || (BYP && in_valid);
            exp_i = (mq.size() != 0) ? mq[0] : in_inst;
            total++;
            if (count !== CW'(mq.size()) || in_ready !== (mq.size() != DEPTH)
                || out_valid !== exp_v || (exp_v && out_inst !== exp_i)) begin
                bad++;
                $display("FAIL random[%0d]: count=%0d rdy=%b valid=%b inst=%h want %0d/%b/%b/%h",
                         i, count, in_ready, out_valid, out_inst, mq.size(),
                         (mq.size() != DEPTH), exp_v, exp_i);
            end
            tick();
        end
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        test_reset();
        test_single_push();
        test_fill();
        test_back_to_back();
        test_flush();
        test_reset_priority();
        test_bypass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
